// File: rtl/scan_pkg.sv
// scan_pkg: shared digit count, index type and all-off enable pattern for the display scan controller
package scan_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int IDX_W = 2;
  localparam logic [NUM_DIGITS-1:0] DIGIT_OFF = 4'b1111;
  typedef enum logic [IDX_W-1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;
endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: slot timer counting 0..REFRESH_DIV-1; ports Clk, Reset_n, zero (count==0), tc (terminal count)
module refresh_prescaler #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic Clk,
  input  logic Reset_n,
  output logic zero,
  output logic tc
);
  localparam int W = $clog2(REFRESH_DIV);
  logic [W-1:0] pcnt;
  assign zero = pcnt == '0;
  assign tc = pcnt == W'(REFRESH_DIV - 1);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) pcnt <= '0;
    else pcnt <= tc ? '0 : pcnt + 1'b1;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit seven-segment scanner; in Clk, Reset_n, Value, Load, BlankLz; out Nibble, DigitSel (active low), FrameDone
module display_scan_ctrl
  import scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic [15:0]           Value,
  input  logic                  Load,
  input  logic                  BlankLz,
  output logic [3:0]            Nibble,
  output logic [NUM_DIGITS-1:0] DigitSel,
  output logic                  FrameDone
);
  digit_t state, state_d;
  logic zero, tc, commit, pend_v, bl_q, blank;
  logic [15:0] disp, pend, upper;
  refresh_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_pre (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .zero(zero),
    .tc(tc)
  );
  assign commit = tc && state == DIG3;
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) state <= DIG0;
    else state <= state_d;
  always_comb begin
    state_d = tc ? digit_t'(state + 1'b1) : state;
  end
  // A load landing on the commit edge bypasses the pending register.
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      disp <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      bl_q <= 1'b0;
      FrameDone <= 1'b0;
    end else begin
      bl_q <= BlankLz;
      FrameDone <= commit;
      if (Load) pend <= Value;
      if (commit) begin
        disp <= Load ? Value : pend_v ? pend : disp;
        pend_v <= 1'b0;
      end else if (Load) pend_v <= 1'b1;
    end
  assign upper = disp >> {state, 2'b00};
  assign Nibble = upper[3:0];
  assign blank = bl_q && state != DIG0 && upper == '0;
  assign DigitSel = (zero || blank) ? DIGIT_OFF : ~(4'b0001 << state);
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed checks of scan order, guard cycles, frame commit, blanking and async reset
module tb_display_scan_ctrl;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic [15:0] Value = '0;
  logic Load = 1'b0;
  logic BlankLz = 1'b0;
  logic [3:0] Nibble;
  logic [3:0] DigitSel;
  logic FrameDone;
  int n_run = 0;
  int n_fail = 0;
  display_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Value(Value),
    .Load(Load),
    .BlankLz(BlankLz),
    .Nibble(Nibble),
    .DigitSel(DigitSel),
    .FrameDone(FrameDone)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  // One 16-cycle frame starting on its guard cycle; nib/sel hold per-slot nibble and lit enable, slot i in [4i+3:4i].
  task automatic run_frame(input logic [15:0] nib, input logic [15:0] sel, input logic fd0,
                           input int la, input logic [15:0] lv, input int lb, input logic [15:0] lvb);
    for (int j = 0; j < 16; j++) begin
      int s;
      s = j / 4;
      chk($sformatf("fd j%0d", j), 16'(FrameDone), 16'((j == 0) ? fd0 : 1'b0));
      chk($sformatf("nib j%0d", j), 16'(Nibble), 16'(nib[4*s +: 4]));
      chk($sformatf("sel j%0d", j), 16'(DigitSel), 16'((j % 4 == 0) ? 4'hF : sel[4*s +: 4]));
      Load = (j == la) || (j == lb);
      Value = (j == lb) ? lvb : lv;
      @(negedge Clk);
    end
    Load = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge Clk);
    chk("rst sel", 16'(DigitSel), 16'hF);
    chk("rst nib", 16'(Nibble), 16'h0);
    chk("rst fd", 16'(FrameDone), 16'h0);
    Reset_n = 1'b1;
    run_frame(16'h0000, 16'h7BDE, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame(16'h0000, 16'h7BDE, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame(16'h0000, 16'h7BDE, 1'b1, 5, 16'h1234, -1, 16'h0);
    run_frame(16'h1234, 16'h7BDE, 1'b1, 2, 16'hAAAA, 9, 16'hBEEF);
    BlankLz = 1'b1;
    run_frame(16'hBEEF, 16'h7BDE, 1'b1, 15, 16'h00C0, -1, 16'h0);
    run_frame(16'h00C0, 16'hFFDE, 1'b1, 15, 16'h0000, -1, 16'h0);
    run_frame(16'h0000, 16'hFFFE, 1'b1, 15, 16'h5678, -1, 16'h0);
    chk("f7 fd", 16'(FrameDone), 16'h1);
    chk("f7 nib", 16'(Nibble), 16'h8);
    Load = 1'b1;
    Value = 16'h9999;
    @(negedge Clk);
    Load = 1'b0;
    @(negedge Clk);
    chk("pre-rst sel", 16'(DigitSel), 16'hE);
    chk("pre-rst nib", 16'(Nibble), 16'h8);
    #2 Reset_n = 1'b0;
    #1;
    chk("async sel", 16'(DigitSel), 16'hF);
    chk("async nib", 16'(Nibble), 16'h0);
    chk("async fd", 16'(FrameDone), 16'h0);
    BlankLz = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    run_frame(16'h0000, 16'h7BDE, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame(16'h0000, 16'h7BDE, 1'b1, -1, 16'h0, -1, 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
